// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump flush, operand forwarding,
// debug halt sequencing (RUN -> DRAIN -> HALTED) and stall/flush performance counters.
//   state  | meaning
//   RUN    | normal issue, hazards resolved per cycle
//   DRAIN  | fetch bubbled, counting down DRAIN_CYC cycles before halting
//   HALTED | pipeline frozen with halt_ack raised
module hazard_ctrl #(
  parameter int DRAIN_CYC = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_rt_used,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_memread,
  input  logic             br_taken,
  input  logic             ex_jump,
  input  logic             mem_regwr,
  input  logic [4:0]       mem_dst,
  input  logic             wb_regwr,
  input  logic [4:0]       wb_dst,
  input  logic             halt_req,
  input  logic             clr_cnt,
  output logic             pc_wr,
  output logic             ifid_wr,
  output logic             ifid_flush,
  output logic             Load_Use,
  output logic             Branch_fc,
  output logic             Jump_fc,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halt_ack,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  localparam int DW = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_HALT  = 2'b10
  } st_t;

  st_t          cur_st, nxt_st;
  logic [DW-1:0] drain_cnt, nxt_cnt;
  logic          lu;
  logic          redirect;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic m_wr, input logic [4:0] m_dst,
                                         input logic w_wr, input logic [4:0] w_dst);
    if (m_wr && (m_dst != 5'd0) && (m_dst == src))      return 2'b01;
    else if (w_wr && (w_dst != 5'd0) && (w_dst == src)) return 2'b10;
    else                                                return 2'b00;
  endfunction

  assign state = cur_st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_st    <= ST_RUN;
      drain_cnt <= '0;
      halt_ack  <= 1'b0;
    end else begin
      cur_st    <= nxt_st;
      drain_cnt <= nxt_cnt;
      halt_ack  <= (nxt_st == ST_HALT);
    end
  end

  always_comb begin
    nxt_st  = cur_st;
    nxt_cnt = drain_cnt;
    case (cur_st)
      ST_RUN: begin
        if (halt_req) begin
          nxt_st  = ST_DRAIN;
          nxt_cnt = DW'(DRAIN_CYC - 1);
        end
      end
      ST_DRAIN: begin
        if (!halt_req) begin
          nxt_st  = ST_RUN;
          nxt_cnt = '0;
        end else if (drain_cnt == '0) begin
          nxt_st  = ST_HALT;
        end else begin
          nxt_cnt = drain_cnt - DW'(1);
        end
      end
      ST_HALT: begin
        if (!halt_req) nxt_st = ST_RUN;
      end
      default: begin
        nxt_st  = ST_RUN;
        nxt_cnt = '0;
      end
    endcase
  end

  assign lu       = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_rt_used && (ex_rt == id_rt)));
  assign redirect = br_taken || ex_jump;

  // Reset gating keeps the pipeline frozen on a bubble while rst_n is low.
  always_comb begin
    pc_wr      = 1'b0;
    ifid_wr    = 1'b0;
    ifid_flush = 1'b1;
    Load_Use   = 1'b0;
    Branch_fc  = 1'b0;
    Jump_fc    = 1'b0;
    fwd_a      = 2'b00;
    fwd_b      = 2'b00;
    if (rst_n) begin
      Branch_fc = br_taken;
      Jump_fc   = ex_jump && !br_taken;
      fwd_a     = fwd_sel(ex_rs, mem_regwr, mem_dst, wb_regwr, wb_dst);
      fwd_b     = fwd_sel(ex_rt, mem_regwr, mem_dst, wb_regwr, wb_dst);
      case (cur_st)
        ST_RUN: begin
          if (redirect) begin
            pc_wr      = 1'b1;
            ifid_wr    = 1'b1;
            ifid_flush = 1'b1;
          end else if (lu) begin
            Load_Use   = 1'b1;
            ifid_flush = 1'b0;
          end else begin
            pc_wr      = 1'b1;
            ifid_wr    = 1'b1;
            ifid_flush = 1'b0;
          end
        end
        ST_DRAIN: begin
          pc_wr      = redirect;
          ifid_wr    = 1'b1;
          ifid_flush = 1'b1;
        end
        default: begin
          pc_wr      = 1'b0;
          ifid_wr    = 1'b1;
          ifid_flush = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (Load_Use && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((Branch_fc || Jump_fc) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
